// File: rtl/kc705_eth_pkg.sv
// Shared definitions for the KC705 Ethernet TX encoder: FSM states, frame
// layout constants, the AXIS byte payload and a header byte selector.
package kc705_eth_pkg;

    localparam int unsigned CNT_W          = 16;
    localparam int unsigned ETH_ADDR_BYTES = 12;
    localparam int unsigned ETH_TYPE_BYTES = 2;
    localparam int unsigned VLAN_TAG_BYTES = 4;
    localparam int unsigned HDR_IDX_W      = 4;
    localparam int unsigned HDR_W          = 8 * ETH_ADDR_BYTES;
    localparam logic [15:0] VLAN_TPID      = 16'h8100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_VLAN,
        ST_TYPE,
        ST_PAYLOAD,
        ST_PAD,
        ST_DISCARD,
        ST_GAP
    } tx_state_e;

    typedef struct packed {
        logic [7:0] tdata;
        logic       tvalid;
        logic       tlast;
    } axis_byte_t;

    // Picks byte 'rem' counted from the LSB end, so rem = last_idx - idx
    // walks a header field MSB byte first.
    function automatic logic [7:0] hdr_byte(input logic [HDR_W-1:0]     bytes,
                                            input logic [HDR_IDX_W-1:0] rem);
        logic [HDR_W-1:0] sh;
        sh = bytes >> {rem, 3'b000};
        return sh[7:0];
    endfunction

endpackage

// File: rtl/kc705_eth_tx_out_reg.sv
// Single-entry AXI-Stream byte register shared by the header, pad and
// payload paths.
//   axi_tclk_i, axi_tresetn_i : clock, async active-high reset
//   load                      : capture din this cycle
//   din                       : next byte/valid/last
//   tdata, tvalid, tlast      : registered stream outputs
module kc705_eth_tx_out_reg
    import kc705_eth_pkg::*;
(
    input  logic       axi_tclk_i,
    input  logic       axi_tresetn_i,
    input  logic       load,
    input  axis_byte_t din,
    output logic [7:0] tdata,
    output logic       tvalid,
    output logic       tlast
);

    always_ff @(posedge axi_tclk_i or posedge axi_tresetn_i) begin
        if (axi_tresetn_i) begin
            tdata  <= 8'h00;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end else if (load) begin
            tdata  <= din.tdata;
            tvalid <= din.tvalid;
            tlast  <= din.tlast;
        end
    end

endmodule

// File: rtl/kc705_ethernet_rgmii_axi_tx_encoder.sv
// Wraps a raw byte payload stream into an Ethernet II frame (dest MAC,
// src MAC, optional 802.1Q tag, EtherType), zero-pads short payloads and
// truncates long ones, and drives an 8-bit AXI-Stream to the TX MAC.
//   axi_tclk_i, axi_tresetn_i : clock, async active-high reset
//   enable_tx_encode          : allows new frames to start
//   s_axis_*                  : payload input stream
//   m_axis_*                  : framed output stream (registered)
//   frame_error               : one-cycle pulse on truncation
//   tx_busy                   : high outside IDLE
//   frame_count               : completed frames, wraps at 16 bits
module kc705_ethernet_rgmii_axi_tx_encoder
    import kc705_eth_pkg::*;
#(
    parameter logic [47:0] DEST_ADDR     = 48'h985aebdb066f,
    parameter logic [47:0] SRC_ADDR      = 48'hc3c4c5c6c7c8,
    parameter logic [15:0] ETHERTYPE     = 16'h0022,
    parameter logic [15:0] MAX_SIZE      = 16'd1500,
    parameter logic [15:0] MIN_SIZE      = 16'd46,
    parameter logic        ENABLE_VLAN   = 1'b0,
    parameter logic [11:0] VLAN_ID       = 12'd2,
    parameter logic [2:0]  VLAN_PRIORITY = 3'd2,
    parameter logic [7:0]  IFG_CYCLES    = 8'd12
) (
    input  logic        axi_tclk_i,
    input  logic        axi_tresetn_i,
    input  logic        enable_tx_encode,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        frame_error,
    output logic        tx_busy,
    output logic [15:0] frame_count
);

    localparam logic [HDR_W-1:0] ADDR_BYTES = {DEST_ADDR, SRC_ADDR};
    localparam logic [HDR_W-1:0] VLAN_BYTES =
        HDR_W'({VLAN_TPID, VLAN_PRIORITY, 1'b0, VLAN_ID});
    localparam logic [HDR_W-1:0] TYPE_BYTES = HDR_W'(ETHERTYPE);
    localparam logic [HDR_IDX_W-1:0] ADDR_LAST = HDR_IDX_W'(ETH_ADDR_BYTES - 1);
    localparam logic [HDR_IDX_W-1:0] VLAN_LAST = HDR_IDX_W'(VLAN_TAG_BYTES - 1);
    localparam logic [HDR_IDX_W-1:0] TYPE_LAST = HDR_IDX_W'(ETH_TYPE_BYTES - 1);

    tx_state_e             state_q, state_d;
    logic [HDR_IDX_W-1:0]  hdr_idx_q, hdr_idx_d;
    logic [CNT_W-1:0]      pay_cnt_q, pay_cnt_d, pay_cnt_inc;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic                  load_c;
    logic                  in_ready_c;
    logic                  err_d;
    axis_byte_t            out_d;

    // Output stage can take a new byte when empty or being drained.
    assign load_c        = !m_axis_tvalid || m_axis_tready;
    // Combinational: payload acceptance follows output-stage availability.
    assign s_axis_tready = in_ready_c;

    // Next-state, header/pad/payload mux and counter updates.
    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        pay_cnt_d   = pay_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        out_d       = '0;
        in_ready_c  = 1'b0;
        err_d       = 1'b0;
        pay_cnt_inc = pay_cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (enable_tx_encode && s_axis_tvalid) begin
                    state_d   = ST_ADDR;
                    hdr_idx_d = '0;
                    pay_cnt_d = '0;
                end
            end
            ST_ADDR: begin
                if (load_c) begin
                    out_d = '{tdata: hdr_byte(ADDR_BYTES, ADDR_LAST - hdr_idx_q),
                              tvalid: 1'b1, tlast: 1'b0};
                    hdr_idx_d = hdr_idx_q + HDR_IDX_W'(1);
                    if (hdr_idx_q == ADDR_LAST) begin
                        hdr_idx_d = '0;
                        state_d   = ENABLE_VLAN ? ST_VLAN : ST_TYPE;
                    end
                end
            end
            ST_VLAN: begin
                if (load_c) begin
                    out_d = '{tdata: hdr_byte(VLAN_BYTES, VLAN_LAST - hdr_idx_q),
                              tvalid: 1'b1, tlast: 1'b0};
                    hdr_idx_d = hdr_idx_q + HDR_IDX_W'(1);
                    if (hdr_idx_q == VLAN_LAST) begin
                        hdr_idx_d = '0;
                        state_d   = ST_TYPE;
                    end
                end
            end
            ST_TYPE: begin
                if (load_c) begin
                    out_d = '{tdata: hdr_byte(TYPE_BYTES, TYPE_LAST - hdr_idx_q),
                              tvalid: 1'b1, tlast: 1'b0};
                    hdr_idx_d = hdr_idx_q + HDR_IDX_W'(1);
                    if (hdr_idx_q == TYPE_LAST) begin
                        hdr_idx_d = '0;
                        state_d   = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                in_ready_c = load_c;
                // With no input byte the stage loads an empty slot (bubble).
                if (load_c && s_axis_tvalid) begin
                    out_d     = '{tdata: s_axis_tdata, tvalid: 1'b1, tlast: 1'b0};
                    pay_cnt_d = pay_cnt_inc;
                    if (s_axis_tlast) begin
                        if (pay_cnt_inc < MIN_SIZE) begin
                            state_d = ST_PAD;
                        end else begin
                            out_d.tlast = 1'b1;
                            gap_cnt_d   = '0;
                            state_d     = ST_GAP;
                        end
                    end else if (pay_cnt_inc == MAX_SIZE) begin
                        out_d.tlast = 1'b1;
                        err_d       = 1'b1;
                        state_d     = ST_DISCARD;
                    end
                end
            end
            ST_PAD: begin
                if (load_c) begin
                    out_d     = '{tdata: 8'h00, tvalid: 1'b1, tlast: 1'b0};
                    pay_cnt_d = pay_cnt_inc;
                    if (pay_cnt_inc >= MIN_SIZE) begin
                        out_d.tlast = 1'b1;
                        gap_cnt_d   = '0;
                        state_d     = ST_GAP;
                    end
                end
            end
            ST_DISCARD: begin
                in_ready_c = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                // Hold the count until the final byte has left the stage.
                if (m_axis_tvalid && m_axis_tlast) begin
                    gap_cnt_d = '0;
                end else if ({1'b0, gap_cnt_q} + 9'd1 >= {1'b0, IFG_CYCLES}) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and status registers.
    always_ff @(posedge axi_tclk_i or posedge axi_tresetn_i) begin
        if (axi_tresetn_i) begin
            state_q     <= ST_IDLE;
            hdr_idx_q   <= '0;
            pay_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            frame_error <= 1'b0;
            tx_busy     <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            pay_cnt_q   <= pay_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_error <= err_d;
            tx_busy     <= (state_d != ST_IDLE);
            if (m_axis_tvalid && m_axis_tlast && m_axis_tready) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    kc705_eth_tx_out_reg u_out_reg (
        .axi_tclk_i    (axi_tclk_i),
        .axi_tresetn_i (axi_tresetn_i),
        .load          (load_c),
        .din           (out_d),
        .tdata         (m_axis_tdata),
        .tvalid        (m_axis_tvalid),
        .tlast         (m_axis_tlast)
    );

endmodule

// File: tb/tb_kc705_ethernet_rgmii_axi_tx_encoder.sv
// Randomized bench for the TX encoder: two instances (VLAN off / on), each
// driven with random payloads, bubbles and backpressure, checked against a
// frame-level model of the expected wire bytes.
`timescale 1ns/1ps
module tb_kc705_ethernet_rgmii_axi_tx_encoder;

    localparam logic [47:0] TB_DEST = 48'h985aebdb066f;
    localparam logic [47:0] TB_SRC  = 48'hc3c4c5c6c7c8;
    localparam logic [15:0] TB_TYPE = 16'h0022;
    localparam int          TB_MIN  = 46;
    localparam int          TB_MAX  = 500;
    localparam logic [11:0] TB_VID  = 12'd2;
    localparam logic [2:0]  TB_PCP  = 3'd2;
    localparam int          TB_IFG  = 12;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } ob_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam logic VL = (g == 1) ? 1'b1 : 1'b0;

        logic        rst, en, s_tvalid, s_tlast, s_tready;
        logic [7:0]  s_tdata, m_tdata;
        logic        m_tvalid, m_tlast, m_tready, frame_error, tx_busy;
        logic [15:0] frame_count;

        kc705_ethernet_rgmii_axi_tx_encoder #(
            .DEST_ADDR(TB_DEST), .SRC_ADDR(TB_SRC), .ETHERTYPE(TB_TYPE),
            .MAX_SIZE(16'(TB_MAX)), .MIN_SIZE(16'(TB_MIN)), .ENABLE_VLAN(VL),
            .VLAN_ID(TB_VID), .VLAN_PRIORITY(TB_PCP), .IFG_CYCLES(8'(TB_IFG))
        ) dut (
            .axi_tclk_i(clk), .axi_tresetn_i(rst), .enable_tx_encode(en),
            .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
            .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
            .m_axis_tlast(m_tlast), .m_axis_tready(m_tready), .frame_error(frame_error),
            .tx_busy(tx_busy), .frame_count(frame_count)
        );

        logic [7:0] pay_q[$];
        ob_t        exp_q[$];
        int         pi, cyc, hs_cyc, fc_model, err_seen;
        bit         acc, stalled, in_out, fin;
        logic [7:0] prev_data;
        logic       prev_last;

        // Expected wire bytes for the payload in pay_q.
        task automatic build_model();
            int n, out_n;
            exp_q.delete();
            for (int i = 5; i >= 0; i--) exp_q.push_back('{d: 8'(TB_DEST >> (8 * i)), l: 1'b0});
            for (int i = 5; i >= 0; i--) exp_q.push_back('{d: 8'(TB_SRC >> (8 * i)), l: 1'b0});
            if (VL) begin
                exp_q.push_back('{d: 8'h81, l: 1'b0});
                exp_q.push_back('{d: 8'h00, l: 1'b0});
                exp_q.push_back('{d: {TB_PCP, 1'b0, TB_VID[11:8]}, l: 1'b0});
                exp_q.push_back('{d: TB_VID[7:0], l: 1'b0});
            end
            exp_q.push_back('{d: TB_TYPE[15:8], l: 1'b0});
            exp_q.push_back('{d: TB_TYPE[7:0], l: 1'b0});
            n     = pay_q.size();
            out_n = (n < TB_MIN) ? TB_MIN : ((n > TB_MAX) ? TB_MAX : n);
            for (int i = 0; i < out_n; i++)
                exp_q.push_back('{d: (i < n) ? pay_q[i] : 8'h00, l: (i == out_n - 1)});
        endtask

        task automatic fill(input int n, input bit incr);
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back(incr ? 8'(i) : 8'($urandom_range(255)));
            build_model();
        endtask

        // One clock: drive after the edge, check at the falling edge.
        task automatic step();
            ob_t e;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                s_tvalid = 1'b0;
                acc      = 1'b0;
            end
            m_tready = (cyc <= 32) ? 1'b0 : 1'($urandom_range(1));
            if (!s_tvalid && pi < pay_q.size() && $urandom_range(99) < 80) begin
                s_tvalid = 1'b1;
                s_tdata  = pay_q[pi];
                s_tlast  = (pi == pay_q.size() - 1);
            end
            @(negedge clk);
            if (stalled) begin
                chk("hold_valid", 32'(m_tvalid), 32'd1);
                chk("hold_data", 32'(m_tdata), 32'(prev_data));
                chk("hold_last", 32'(m_tlast), 32'(prev_last));
            end
            stalled   = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_last = m_tlast;
            if (m_tvalid && !in_out) begin
                in_out = 1'b1;
                if (hs_cyc >= 0) begin
                    n_checks++;
                    if (cyc - hs_cyc - 1 < TB_IFG) begin
                        n_errors++;
                        $display("FAIL ifg: got %0d idle cycles expected >= %0d", cyc - hs_cyc - 1, TB_IFG);
                    end
                end
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_byte: got %02h expected no byte", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", 32'(m_tdata), 32'(e.d));
                    chk("tlast", 32'(m_tlast), 32'(e.l));
                end
                if (m_tlast) begin
                    hs_cyc = cyc;
                    in_out = 1'b0;
                end
            end
            if (frame_error) err_seen++;
            if (s_tvalid && s_tready) begin
                pi++;
                acc = 1'b1;
            end
        endtask

        task automatic run_frame(input int n, input bit incr, input int en_drop_at);
            int budget;
            fill(n, incr);
            pi = 0; acc = 1'b0; err_seen = 0; budget = 0;
            while ((pi < n || exp_q.size() != 0) && budget < 8000) begin
                if (en_drop_at >= 0 && pi >= en_drop_at) en = 1'b0;
                step();
                budget++;
            end
            if (budget >= 8000) begin
                chk("frame_timeout", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
            end
            step();
            fc_model++;
            chk("frame_count", 32'(frame_count), 32'(fc_model));
            chk("tx_busy_gap", 32'(tx_busy), 32'd1);
            chk("frame_error_pulses", 32'(err_seen), 32'(n > TB_MAX));
        endtask

        initial begin
            int budget;
            rst = 1'b1; en = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0;
            m_tready = 1'b0; cyc = 0; hs_cyc = -1; fc_model = 0; pi = 0;
            acc = 1'b0; stalled = 1'b0; in_out = 1'b0; fin = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("rst_tvalid", 32'(m_tvalid), 32'd0);
            chk("rst_tdata", 32'(m_tdata), 32'd0);
            chk("rst_tlast", 32'(m_tlast), 32'd0);
            chk("rst_tready", 32'(s_tready), 32'd0);
            chk("rst_frame_error", 32'(frame_error), 32'd0);
            chk("rst_tx_busy", 32'(tx_busy), 32'd0);
            chk("rst_frame_count", 32'(frame_count), 32'd0);
            rst = 1'b0;
            en  = 1'b1;

            // Hand-computed expectations that pin the model.
            fill(64, 1'b1);
            if (!VL) begin
                chk("model_len64", 32'(exp_q.size()), 32'd78);
                chk("model_b1", 32'(exp_q[0].d), 32'h98);
                chk("model_b12", 32'(exp_q[11].d), 32'hc8);
                chk("model_b14", 32'(exp_q[13].d), 32'h22);
                chk("model_b78", 32'({exp_q[77].d, exp_q[77].l}), 32'h7f);
                fill(10, 1'b0);
                chk("model_len10", 32'(exp_q.size()), 32'd60);
                chk("model_pad25", 32'(exp_q[24].d), 32'h00);
                fill(600, 1'b0);
                chk("model_len600", 32'(exp_q.size()), 32'd514);
            end else begin
                chk("model_vlan_len", 32'(exp_q.size()), 32'd82);
                chk("model_vlan_tag", {exp_q[12].d, exp_q[13].d, exp_q[14].d, exp_q[15].d}, 32'h81004002);
                chk("model_vlan_type", 32'({exp_q[16].d, exp_q[17].d}), 32'h0022);
            end

            run_frame(64, 1'b1, -1);
            run_frame(10, 1'b0, -1);
            if (!VL) begin
                run_frame(600, 1'b0, -1);
                run_frame(46, 1'b0, -1);
                run_frame(45, 1'b0, -1);
                run_frame(500, 1'b0, -1);
                run_frame(501, 1'b0, -1);
                run_frame(1, 1'b0, -1);
                for (int k = 0; k < 12; k++) run_frame(int'($urandom_range(560, 1)), 1'b0, -1);

                // Enable drops mid-frame: frame completes, nothing new starts.
                run_frame(80, 1'b0, 5);
                pay_q.delete();
                pay_q.push_back(8'h55);
                pi = 0;
                repeat (40) step();
                chk("noen_tx_busy", 32'(tx_busy), 32'd0);
                chk("noen_consumed", 32'(pi), 32'd0);
                chk("noen_tvalid", 32'(m_tvalid), 32'd0);
                s_tvalid = 1'b0;
                en       = 1'b1;
                run_frame(30, 1'b0, -1);

                // Reset in the middle of the payload.
                fill(64, 1'b0);
                pi = 0; acc = 1'b0; budget = 0;
                while (pi < 30 && budget < 4000) begin
                    step();
                    budget++;
                end
                chk("rst_mid_reached", 32'(pi), 32'd30);
                #1 rst = 1'b1;
                #1;
                chk("rstmid_tvalid", 32'(m_tvalid), 32'd0);
                chk("rstmid_tlast", 32'(m_tlast), 32'd0);
                chk("rstmid_tx_busy", 32'(tx_busy), 32'd0);
                chk("rstmid_frame_count", 32'(frame_count), 32'd0);
                chk("rstmid_tready", 32'(s_tready), 32'd0);
                exp_q.delete();
                fc_model = 0; s_tvalid = 1'b0; acc = 1'b0; stalled = 1'b0;
                in_out = 1'b0; hs_cyc = -1;
                @(posedge clk);
                @(posedge clk);
                #1 rst = 1'b0;
                run_frame(20, 1'b0, -1);
            end else begin
                run_frame(int'($urandom_range(120, 1)), 1'b0, -1);
            end
            fin = 1'b1;
        end
    end

    initial begin
        wait (inst[0].fin && inst[1].fin);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kc705_ethernet_rgmii_axi_tx_encoder.md
Name: kc705_ethernet_rgmii_axi_tx_encoder

Overview:
Transmit-side counterpart of the RX frame decoder. It takes a raw byte-wide payload stream from the GPR data path and wraps it in an Ethernet II frame: destination MAC, source MAC, optional 802.1Q tag and EtherType. Payloads shorter than MIN_SIZE are zero-padded; payloads longer than MAX_SIZE are truncated. The output is an 8-bit AXI-Stream feeding the TX MAC client interface.

Parameters:
DEST_ADDR, 48'h985aebdb066f, destination MAC; sent MSB byte first.
SRC_ADDR, 48'hc3c4c5c6c7c8, source MAC; sent MSB byte first.
ETHERTYPE, 16'h0022, type field; sent MSB byte first.
MAX_SIZE, 16'd1500, maximum payload bytes per frame (header excluded).
MIN_SIZE, 16'd46, minimum payload bytes per frame; must satisfy MIN_SIZE <= MAX_SIZE.
ENABLE_VLAN, 1'b0, insert an 802.1Q tag when 1.
VLAN_ID, 12'd2, VID field of the tag.
VLAN_PRIORITY, 3'd2, PCP field of the tag.
IFG_CYCLES, 8'd12, minimum idle cycles between frames.

Ports:
axi_tclk_i  in  1  clock.
axi_tresetn_i  in  1  reset; asynchronous, active-high.
enable_tx_encode  in  1  permits new frames to start.
s_axis_tdata  in  8  payload byte.
s_axis_tvalid  in  1  payload valid.
s_axis_tlast  in  1  last payload byte of the frame.
s_axis_tready  out  1  payload accepted.
m_axis_tdata  out  8  frame byte.
m_axis_tvalid  out  1  frame byte valid.
m_axis_tlast  out  1  last byte of the frame.
m_axis_tready  in  1  downstream ready.
frame_error  out  1  one-cycle pulse when a frame is truncated.
tx_busy  out  1  high in every state except IDLE.
frame_count  out  16  number of completed frames; wraps at 16 bits.

Behaviour:
- Reset: axi_tclk_i is the clock; axi_tresetn_i is asynchronous and active-high. While asserted, state=IDLE and all outputs are 0 (m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0, frame_error=0, tx_busy=0, frame_count=0). A reset mid-frame aborts the frame with no m_axis_tlast; the next frame starts from DEST_ADDR byte 0.
- Output register stage: m_axis_* is registered and loads when (!m_axis_tvalid || m_axis_tready). Data is held stable while m_axis_tvalid=1 and m_axis_tready=0. Latency is 1 cycle from payload acceptance to output.
- FSM states: IDLE, ADDR, VLAN, TYPE, PAYLOAD, PAD, DISCARD, GAP.
- IDLE -> ADDR when enable_tx_encode=1 and s_axis_tvalid=1. No payload byte is consumed in this transition.
- ADDR: 12 bytes, DEST_ADDR[47:40] first through SRC_ADDR[7:0]. Exit to VLAN if ENABLE_VLAN=1, else to TYPE.
- VLAN: 4 bytes: 8'h81, 8'h00, {VLAN_PRIORITY,1'b0,VLAN_ID[11:8]}, VLAN_ID[7:0].
- TYPE: 2 bytes, ETHERTYPE[15:8] then ETHERTYPE[7:0].
- PAYLOAD:
  - s_axis_tready = output stage loadable; bytes pass through unchanged.
  - A 16-bit payload counter increments on each accepted byte.
  - s_axis_tvalid=0 mid-payload produces output bubbles (m_axis_tvalid=0); no filler bytes are inserted.
- s_axis_tlast accepted with count < MIN_SIZE: go to PAD. PAD emits 8'h00 until count = MIN_SIZE; m_axis_tlast is set on the final pad byte.
- s_axis_tlast accepted with MIN_SIZE <= count <= MAX_SIZE: m_axis_tlast is set on that byte; go to GAP.
- Count reaches MAX_SIZE without s_axis_tlast:
  - m_axis_tlast is set on byte MAX_SIZE and frame_error pulses for one cycle.
  - Go to DISCARD: s_axis_tready=1, input bytes are dropped until s_axis_tlast is accepted, then go to GAP.
  - s_axis_tlast arriving exactly on byte MAX_SIZE is a normal frame, with no error.
- frame_count increments on the m_axis_tlast handshake.
- GAP: counts IFG_CYCLES cycles starting after the m_axis_tlast handshake, then returns to IDLE. s_axis_tready=0 throughout.
- Frame length on the wire = 14 + (ENABLE_VLAN ? 4 : 0) + clamp(payload, MIN_SIZE, MAX_SIZE).
- enable_tx_encode deasserted mid-frame: the current frame completes; no new frame starts.
- s_axis_tready is 0 in IDLE, ADDR, VLAN, TYPE, PAD and GAP.

Decomposition:
- Shared package kc705_eth_pkg:
  - FSM state enum.
  - Constants ETH_ADDR_BYTES=12, ETH_TYPE_BYTES=2, VLAN_TAG_BYTES=4, VLAN_TPID=16'h8100.
  - Counter width 16.
- One sub-module, kc705_eth_tx_out_reg: single-entry AXIS byte register with tdata/tvalid/tlast and load enable. It is reused by the header, pad and payload muxes.

Test Plan:
- 64-byte payload 0x00..0x3F, VLAN off -> 78 bytes out: 98 5a eb db 06 6f c3 c4 c5 c6 c7 c8 00 22 00..3F; tlast on byte 78; frame_count=1.
- 10-byte payload, MIN_SIZE=46 -> 60 bytes out; bytes 25..60 = 00; tlast on byte 60; frame_error=0.
- 600-byte payload, MAX_SIZE=500 -> 514 bytes out with tlast on byte 514; frame_error pulses once; 100 bytes are consumed with s_axis_tready=1 and never output.
- ENABLE_VLAN=1, VID=2, PCP=2, 64-byte payload -> bytes 13..16 = 81 00 40 02; bytes 17..18 = 00 22; 82 bytes total.
- m_axis_tready low for 32 cycles after reset, then random 50% backpressure over 20 frames -> sequence matches the model with no loss or duplication; m_axis_tdata stable while stalled; at least 12 idle cycles between each tlast handshake and the next valid byte.
- Reset asserted at payload byte 30 -> m_axis_tvalid=0, tx_busy=0 immediately; after release, the next frame's first byte is 98.
